// File: rtl/pc_update_ctrl.sv
// pc_update_ctrl
//
// Sequences PC updates for the multicycle datapath. One request per
// instruction arrives from the main control unit. The block evaluates branch
// conditions and runs the exception-entry sequence (EPC save, vector fetch,
// PC load). It is the sole driver of PCSource, PCWrite and EPCWrite.
//
// Handshake: a request transfers on a rising edge where req_valid=1 and
// req_ready=1. req_ready is high only while the sequencer is idle. The
// requester holds req_valid and its payload (req_kind, exc_cause) until the
// transfer edge. req_valid seen while req_ready=0 has no effect.
//
// Parameters
//   MEM_LAT    memory read latency in cycles (1..7)
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   req_valid  request strobe
//   req_kind   0 SEQ, 1 BEQ, 2 BNE, 3 JUMP, 4 JR, 5 RTE, 6 EXC, 7 reserved
//   exc_cause  0 invalid opcode, 1 overflow, 2 divide-by-zero, 3 reserved
//   zero       ALU zero flag, used in the branch-evaluate cycle
//   req_ready  high while idle
//   done       one-cycle pulse when a request completes
//   PCSource   PC mux select (001 ALU, 010 EPC, 011 MDR, 100 ALUOut,
//              101 JumpAddress, 111 RegA)
//   PCWrite    PC load strobe
//   EPCWrite   EPC load strobe
//   MemRead    memory read strobe during vector fetch
//   ExcVecSel  vector address select during vector fetch
//   Cause      cause of the most recent exception
//   dbg_state  current FSM state
module pc_update_ctrl #(
  parameter int MEM_LAT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [2:0] req_kind,
  input  logic [1:0] exc_cause,
  input  logic       zero,
  output logic       req_ready,
  output logic       done,
  output logic [2:0] PCSource,
  output logic       PCWrite,
  output logic       EPCWrite,
  output logic       MemRead,
  output logic [1:0] ExcVecSel,
  output logic [1:0] Cause,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WRITE    = 3'd1,
    S_BR_EVAL  = 3'd2,
    S_EXC_SAVE = 3'd3,
    S_EXC_WAIT = 3'd4,
    S_EXC_LOAD = 3'd5
  } state_t;

  localparam logic [2:0] K_SEQ  = 3'd0;
  localparam logic [2:0] K_BEQ  = 3'd1;
  localparam logic [2:0] K_BNE  = 3'd2;
  localparam logic [2:0] K_JUMP = 3'd3;
  localparam logic [2:0] K_JR   = 3'd4;
  localparam logic [2:0] K_RTE  = 3'd5;
  localparam logic [2:0] K_EXC  = 3'd6;
  localparam logic [2:0] K_RSV  = 3'd7;

  localparam logic [2:0] SRC_ALU    = 3'b001;
  localparam logic [2:0] SRC_EPC    = 3'b010;
  localparam logic [2:0] SRC_MDR    = 3'b011;
  localparam logic [2:0] SRC_ALUOUT = 3'b100;
  localparam logic [2:0] SRC_JADDR  = 3'b101;
  localparam logic [2:0] SRC_REGA   = 3'b111;

  // The counter holds the number of MemRead cycles still to come after the
  // current one, so EXC_SAVE plus EXC_WAIT together span exactly MEM_LAT
  // cycles (EXC_WAIT is skipped entirely when MEM_LAT is 1).
  localparam logic [2:0] CNT_INIT = 3'(MEM_LAT - 1);

  state_t     state_q, state_d;
  logic [2:0] kind_q;
  logic [2:0] cnt_q;
  logic [1:0] cause_q;

  logic       accept;
  logic       is_exc_req;
  logic [1:0] eff_cause;
  logic       taken;
  logic [2:0] req_src;

  logic       ready_d, done_d, pcw_d, epcw_d, mr_d;
  logic [2:0] src_d;
  logic [1:0] vsel_d;

  assign accept     = (state_q == S_IDLE) && req_valid;
  assign is_exc_req = (req_kind == K_EXC) || (req_kind == K_RSV);

  // Reserved kind 7 is treated as an invalid-opcode exception; reserved
  // cause 3 also folds onto cause 0.
  assign eff_cause = ((req_kind == K_RSV) || (exc_cause == 2'd3)) ? 2'd0 : exc_cause;

  assign taken = (kind_q == K_BEQ) ? zero : ~zero;

  always_comb begin
    req_src = SRC_ALU;
    case (req_kind)
      K_JUMP:  req_src = SRC_JADDR;
      K_JR:    req_src = SRC_REGA;
      K_RTE:   req_src = SRC_EPC;
      default: req_src = SRC_ALU;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          case (req_kind)
            K_SEQ, K_JUMP, K_JR, K_RTE: state_d = S_WRITE;
            K_BEQ, K_BNE:               state_d = S_BR_EVAL;
            default:                    state_d = S_EXC_SAVE;
          endcase
        end
      end
      S_WRITE:    state_d = S_IDLE;
      S_BR_EVAL:  state_d = S_WRITE;
      S_EXC_SAVE: state_d = (cnt_q == 3'd0) ? S_EXC_LOAD : S_EXC_WAIT;
      S_EXC_WAIT: if (cnt_q == 3'd0) state_d = S_EXC_LOAD;
      S_EXC_LOAD: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Request payload, wait counter and cause latch
  always_ff @(posedge clk) begin
    if (reset) begin
      kind_q  <= K_SEQ;
      cnt_q   <= 3'd0;
      cause_q <= 2'd0;
    end else begin
      if (accept) begin
        kind_q <= req_kind;
        cnt_q  <= CNT_INIT;
        if (is_exc_req) cause_q <= eff_cause;
      end else if (((state_q == S_EXC_SAVE) || (state_q == S_EXC_WAIT)) &&
                   (cnt_q != 3'd0)) begin
        cnt_q <= cnt_q - 3'd1;
      end
    end
  end

  // Output logic: decoded from the state being entered so that every output
  // comes straight from a flop in the cycle that state is active.
  always_comb begin
    ready_d = (state_d == S_IDLE);
    done_d  = 1'b0;
    pcw_d   = 1'b0;
    epcw_d  = 1'b0;
    mr_d    = 1'b0;
    src_d   = SRC_ALU;
    vsel_d  = 2'd0;
    case (state_d)
      S_WRITE: begin
        done_d = 1'b1;
        if (state_q == S_BR_EVAL) begin
          // Not-taken branch: PC already holds PC+4, so no write.
          pcw_d = taken;
          src_d = taken ? SRC_ALUOUT : SRC_ALU;
        end else begin
          pcw_d = 1'b1;
          src_d = req_src;
        end
      end
      S_EXC_SAVE: begin
        epcw_d = 1'b1;
        mr_d   = 1'b1;
        vsel_d = eff_cause;
      end
      S_EXC_WAIT: begin
        mr_d   = 1'b1;
        vsel_d = cause_q;
      end
      S_EXC_LOAD: begin
        pcw_d  = 1'b1;
        done_d = 1'b1;
        src_d  = SRC_MDR;
      end
      default: ;
    endcase
  end

  // Output register; reset drops any strobe that was about to be issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_ready <= 1'b1;
      done      <= 1'b0;
      PCSource  <= SRC_ALU;
      PCWrite   <= 1'b0;
      EPCWrite  <= 1'b0;
      MemRead   <= 1'b0;
      ExcVecSel <= 2'd0;
    end else begin
      req_ready <= ready_d;
      done      <= done_d;
      PCSource  <= src_d;
      PCWrite   <= pcw_d;
      EPCWrite  <= epcw_d;
      MemRead   <= mr_d;
      ExcVecSel <= vsel_d;
    end
  end

  assign Cause     = cause_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pc_update_ctrl.sv
// Testbench for pc_update_ctrl. A per-request model turns each accepted
// request into the list of output vectors it must produce, cycle by cycle;
// one compare process checks the DUT against that list on every cycle.
// Output vector layout: {ready, done, pcw, epcw, mr, src[2:0], vsel[1:0], cause[1:0]}
module tb_pc_update_ctrl;
  localparam int MEM_LAT = 2;
  localparam int W = 12;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic [2:0] req_kind = 3'd0;
  logic [1:0] exc_cause = 2'd0;
  logic       zero = 1'b0;
  logic       req_ready, done, PCWrite, EPCWrite, MemRead;
  logic [2:0] PCSource, dbg_state;
  logic [1:0] ExcVecSel, Cause;

  pc_update_ctrl #(.MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_kind(req_kind),
    .exc_cause(exc_cause), .zero(zero), .req_ready(req_ready), .done(done),
    .PCSource(PCSource), .PCWrite(PCWrite), .EPCWrite(EPCWrite),
    .MemRead(MemRead), .ExcVecSel(ExcVecSel), .Cause(Cause),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int n_chk = 0;
  int n_fail = 0;
  int n_acc = 0;
  int n_abort = 0;
  int n_done = 0;
  logic [W-1:0] exp_q[$];
  logic [1:0]   exp_cause = 2'd0;
  logic [W-1:0] obs [0:4095];

  function automatic logic [W-1:0] rec(input logic rdy, input logic dn,
                                       input logic pcw, input logic epcw,
                                       input logic mr, input logic [2:0] src,
                                       input logic [1:0] vs, input logic [1:0] cs);
    return {rdy, dn, pcw, epcw, mr, src, vs, cs};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- compare process ----------------
  initial begin
    logic [W-1:0] e, a;
    @(posedge clk);
    forever begin
      @(negedge clk);
      a = {req_ready, done, PCWrite, EPCWrite, MemRead, PCSource, ExcVecSel, Cause};
      if (cyc < 4096) obs[cyc] = a;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = rec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 2'd0, exp_cause);
      chk("req_ready", a[11], e[11]);
      chk("done", a[10], e[10]);
      chk("PCWrite", a[9], e[9]);
      chk("EPCWrite", a[8], e[8]);
      chk("MemRead", a[7], e[7]);
      chk("PCSource", a[6:4], e[6:4]);
      if (e[7]) chk("ExcVecSel", a[3:2], e[3:2]);
      chk("Cause", a[1:0], e[1:0]);
      chk("inv_src_legal", (PCSource != 3'b000) && (PCSource != 3'b110), 1);
      chk("inv_no_dual_write", PCWrite & EPCWrite, 0);
      if (done === 1'b1) n_done++;
    end
  end

  // ---------------- driver tasks ----------------
  // Called at #1 after a rising edge. Returns t1 = obs index of cycle T+1,
  // and returns in cycle T+2 (again #1 after the edge).
  task automatic issue(input logic [2:0] k, input logic [1:0] c, input logic zv,
                       output int t1);
    logic acc;
    int guard;
    logic tk;
    logic [1:0] ce;
    logic [2:0] s;
    req_valid = 1'b1;
    req_kind  = k;
    exc_cause = c;
    acc = 1'b0;
    guard = 0;
    while (!acc && guard < 64) begin
      acc = req_ready;
      @(posedge clk);
      if (!acc) #1;
      guard++;
    end
    if (!acc) begin
      chk("accept_timeout", 0, 1);
      req_valid = 1'b0;
      t1 = 0;
      return;
    end
    n_acc++;
    if (k == 3'd1 || k == 3'd2) begin
      tk = (k == 3'd1) ? zv : ~zv;
      exp_q.push_back(rec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 2'd0, exp_cause));
      exp_q.push_back(rec(1'b0, 1'b1, tk, 1'b0, 1'b0, tk ? 3'b100 : 3'b001, 2'd0, exp_cause));
    end else if (k >= 3'd6) begin
      ce = (k == 3'd7 || c == 2'd3) ? 2'd0 : c;
      exp_cause = ce;
      exp_q.push_back(rec(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b001, ce, ce));
      for (int i = 1; i < MEM_LAT; i++)
        exp_q.push_back(rec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001, ce, ce));
      exp_q.push_back(rec(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b011, 2'd0, ce));
    end else begin
      s = (k == 3'd3) ? 3'b101 : (k == 3'd4) ? 3'b111 : (k == 3'd5) ? 3'b010 : 3'b001;
      exp_q.push_back(rec(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, s, 2'd0, exp_cause));
    end
    #1;
    req_valid = 1'b0;
    req_kind  = 3'($urandom_range(0, 7));
    exc_cause = 2'($urandom_range(0, 3));
    zero = zv;
    t1 = cyc;
    @(posedge clk);
    #1;
    zero = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (req_ready !== 1'b1 && g < 64) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (req_ready !== 1'b1) chk("idle_timeout", 0, 1);
  endtask

  // Let the compare process record the current cycle, then realign.
  task automatic sync();
    @(negedge clk);
    #1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t, ta, tb, tc, nd;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_src", PCSource, 3'b001);
    chk("rst_pcw", PCWrite, 0);
    chk("rst_epcw", EPCWrite, 0);
    chk("rst_memrd", MemRead, 0);
    chk("rst_vsel", ExcVecSel, 0);
    chk("rst_cause", Cause, 0);
    @(posedge clk);
    #1;

    // SEQ
    issue(3'd0, 2'd0, 1'b0, t);
    sync();
    chk("seq_pcw", obs[t][9], 1);
    chk("seq_src", obs[t][6:4], 3'b001);
    chk("seq_done", obs[t][10], 1);
    chk("seq_ready_after", obs[t+1][11], 1);

    // Branches
    issue(3'd1, 2'd0, 1'b1, t);
    sync();
    chk("beq_taken_pcw", obs[t+1][9], 1);
    chk("beq_taken_src", obs[t+1][6:4], 3'b100);
    issue(3'd1, 2'd0, 1'b0, t);
    sync();
    chk("beq_nt_pcw", obs[t+1][9], 0);
    chk("beq_nt_done", obs[t+1][10], 1);
    issue(3'd2, 2'd0, 1'b0, t);
    sync();
    chk("bne_taken_pcw", obs[t+1][9], 1);
    chk("bne_taken_src", obs[t+1][6:4], 3'b100);

    // JUMP / JR / RTE back to back
    issue(3'd3, 2'd0, 1'b0, ta);
    issue(3'd4, 2'd0, 1'b0, tb);
    issue(3'd5, 2'd0, 1'b0, tc);
    sync();
    chk("jump_src", obs[ta][6:4], 3'b101);
    chk("jr_src", obs[tb][6:4], 3'b111);
    chk("rte_src", obs[tc][6:4], 3'b010);
    chk("b2b_spacing_1", tb - ta, 2);
    chk("b2b_spacing_2", tc - tb, 2);

    // Exception, cause 1
    issue(3'd6, 2'd1, 1'b0, t);
    wait_idle();
    sync();
    chk("exc_t1_epcw", obs[t][8], 1);
    chk("exc_t1_memrd", obs[t][7], 1);
    chk("exc_t1_vsel", obs[t][3:2], 1);
    chk("exc_t1_cause", obs[t][1:0], 1);
    chk("exc_t2_memrd", obs[t+1][7], 1);
    chk("exc_t2_epcw", obs[t+1][8], 0);
    chk("exc_t3_pcw", obs[t+2][9], 1);
    chk("exc_t3_src", obs[t+2][6:4], 3'b011);
    chk("exc_t3_done", obs[t+2][10], 1);

    // Reserved kind 7 forces cause 0
    issue(3'd7, 2'd2, 1'b0, t);
    wait_idle();
    sync();
    chk("rsv_cause", obs[t][1:0], 0);
    chk("rsv_vsel", obs[t][3:2], 0);
    chk("rsv_load_src", obs[t+2][6:4], 3'b011);

    // Busy: request pulsed during EXC_WAIT is ignored
    issue(3'd6, 2'd2, 1'b0, t);
    req_valid = 1'b1;
    req_kind  = 3'd0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_idle();
    sync();
    sync();
    nd = 0;
    for (int i = 0; i < 5; i++) nd += int'(obs[t+i][10]);
    chk("busy_single_done", nd, 1);
    chk("busy_cause", obs[t+2][1:0], 2);

    // Reset in cycle T+2 of an exception
    issue(3'd6, 2'd1, 1'b0, t);
    reset = 1'b1;
    @(posedge clk);
    exp_q.delete();
    exp_cause = 2'd0;
    n_abort++;
    #1 reset = 1'b0;
    sync();
    chk("abort_no_pcw", obs[t+2][9], 0);
    chk("abort_idle", obs[t+2][11], 1);
    chk("abort_cause", obs[t+2][1:0], 0);
    chk("abort_no_done", obs[t+2][10], 0);

    // Randomized request stream
    for (int n = 0; n < 300; n++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      issue(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), t);
    end
    wait_idle();
    sync();
    sync();
    chk("done_count", n_done, n_acc - n_abort);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
